// File: rtl/freq_nav_pkg.sv
// Shared encodings for the frequency-seeking navigation controller.
package freq_nav_pkg;

    // Motor command encodings (2'b11 is never driven)
    localparam logic [1:0] STOP = 2'b00;
    localparam logic [1:0] FWD  = 2'b01;
    localparam logic [1:0] REV  = 2'b10;

    // Valid band-code window from the frequency detector
    localparam logic [3:0] CODE_MIN = 4'd7;
    localparam logic [3:0] CODE_MAX = 4'd14;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEARCH   = 3'd1,
        ST_APPROACH = 3'd2,
        ST_TURN     = 3'd3,
        ST_ARRIVED  = 3'd4
    } nav_state_t;

    // Unsigned distance between a code and the target band
    function automatic logic [3:0] code_dist(input logic [3:0] target, input logic [3:0] c);
        return (target >= c) ? (target - c) : (c - target);
    endfunction

endpackage

// File: rtl/freq_code_qualifier.sv
// Sample-tick generator plus chatter filter for the detector band code.
module freq_code_qualifier
    import freq_nav_pkg::*;
#(
    parameter int SAMPLE_DIV     = 100000,
    parameter int STABLE_SAMPLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] freq_state,
    output logic       tick,
    output logic [3:0] qual_code
);

    localparam int DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam int RUN_W = $clog2(STABLE_SAMPLES + 1);

    logic [DIV_W-1:0] r_div;
    logic [3:0]       r_cand;
    logic [3:0]       r_qual;
    logic [RUN_W-1:0] r_run;
    logic             w_tick;
    logic [3:0]       w_mapped;
    logic [RUN_W-1:0] w_run_nxt;

    assign w_tick    = (r_div == DIV_W'(SAMPLE_DIV - 1));
    assign tick      = w_tick;
    assign qual_code = r_qual;

    // Free-running sample divider, wraps at SAMPLE_DIV-1
    always_ff @(posedge clk) begin
        if (reset)       r_div <= '0;
        else if (w_tick) r_div <= '0;
        else             r_div <= r_div + DIV_W'(1);
    end

    // Out-of-band codes collapse to 0; run length saturates at STABLE_SAMPLES
    always_comb begin
        w_mapped  = ((freq_state >= CODE_MIN) && (freq_state <= CODE_MAX)) ? freq_state : 4'd0;
        w_run_nxt = RUN_W'(1);
        if (w_mapped == r_cand)
            w_run_nxt = (r_run == RUN_W'(STABLE_SAMPLES)) ? r_run : (r_run + RUN_W'(1));
    end

    // Candidate tracking; publish once the run length hits the threshold
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cand <= 4'd0;
            r_run  <= '0;
            r_qual <= 4'd0;
        end else if (w_tick) begin
            r_cand <= w_mapped;
            r_run  <= w_run_nxt;
            if (w_run_nxt == RUN_W'(STABLE_SAMPLES))
                r_qual <= w_mapped;
        end
    end

endmodule

// File: rtl/freq_nav_controller.sv
// Navigation FSM: search-spin, approach legs and corrective turns toward TARGET_CODE.
module freq_nav_controller
    import freq_nav_pkg::*;
#(
    parameter int SAMPLE_DIV     = 100000,
    parameter int STABLE_SAMPLES = 8,
    parameter int TARGET_CODE    = 14,
    parameter int FWD_TICKS      = 500,
    parameter int TURN_TICKS     = 200,
    parameter int LOST_TICKS     = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] freq_state,
    input  logic       enable,
    output logic [1:0] motor_left,
    output logic [1:0] motor_right,
    output logic [3:0] qual_code,
    output logic       locked,
    output logic [2:0] nav_state
);

    localparam logic [3:0] TGT = 4'(TARGET_CODE);
    localparam int LEG_MAX = (FWD_TICKS > TURN_TICKS) ? FWD_TICKS : TURN_TICKS;
    localparam int LEG_W   = $clog2(LEG_MAX + 1);
    localparam int LOST_W  = $clog2(LOST_TICKS + 1);

    logic              w_tick;
    logic [3:0]        w_qual;
    nav_state_t        r_state, w_nxt;
    logic [LEG_W-1:0]  r_leg, w_leg_nxt, w_leg_inc;
    logic [LOST_W-1:0] r_lost, w_lost_nxt, w_lost_inc;
    logic [3:0]        r_ref, w_ref_nxt, w_qdist;
    logic              w_lost_cond;
    logic [1:0]        r_ml, r_mr, w_ml, w_mr;
    logic              r_lock, w_lock;

    freq_code_qualifier #(
        .SAMPLE_DIV    (SAMPLE_DIV),
        .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_qual (
        .clk       (clk),
        .reset     (reset),
        .freq_state(freq_state),
        .tick      (w_tick),
        .qual_code (w_qual)
    );

    assign w_qdist    = code_dist(TGT, w_qual);
    assign w_leg_inc  = r_leg + LEG_W'(1);
    assign w_lost_inc = r_lost + LOST_W'(1);
    // ARRIVED loses lock on any non-target code; moving states only on "no tone"
    assign w_lost_cond = (r_state == ST_ARRIVED) ? (w_qual != TGT) : (w_qual == 4'd0);

    assign qual_code   = w_qual;
    assign nav_state   = r_state;
    assign motor_left  = r_ml;
    assign motor_right = r_mr;
    assign locked      = r_lock;

    // State, counters and decoded outputs all register on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_leg   <= '0;
            r_lost  <= '0;
            r_ref   <= 4'd0;
            r_ml    <= STOP;
            r_mr    <= STOP;
            r_lock  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_leg   <= w_leg_nxt;
            r_lost  <= w_lost_nxt;
            r_ref   <= w_ref_nxt;
            r_ml    <= w_ml;
            r_mr    <= w_mr;
            r_lock  <= w_lock;
        end
    end

    // Next state: enable low > arrival > lost > leg-end decisions
    always_comb begin
        w_nxt      = r_state;
        w_leg_nxt  = r_leg;
        w_lost_nxt = r_lost;
        w_ref_nxt  = r_ref;
        if (!enable) begin
            w_nxt      = ST_IDLE;
            w_leg_nxt  = '0;
            w_lost_nxt = '0;
        end else if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    w_nxt      = ST_SEARCH;
                    w_leg_nxt  = '0;
                    w_lost_nxt = '0;
                end
                ST_SEARCH: begin
                    w_lost_nxt = '0;
                    if (w_qual == TGT) begin
                        w_nxt = ST_ARRIVED;
                    end else if (w_qual != 4'd0) begin
                        w_nxt     = ST_APPROACH;
                        w_ref_nxt = w_qdist;
                        w_leg_nxt = '0;
                    end
                end
                ST_APPROACH, ST_TURN: begin
                    w_lost_nxt = w_lost_cond ? w_lost_inc : '0;
                    w_leg_nxt  = w_leg_inc;
                    if (w_qual == TGT) begin
                        w_nxt      = ST_ARRIVED;
                        w_leg_nxt  = '0;
                        w_lost_nxt = '0;
                    end else if (w_lost_cond && (w_lost_inc == LOST_W'(LOST_TICKS))) begin
                        w_nxt      = ST_SEARCH;
                        w_leg_nxt  = '0;
                        w_lost_nxt = '0;
                    end else if ((r_state == ST_APPROACH) && (w_leg_inc == LEG_W'(FWD_TICKS))) begin
                        w_leg_nxt = '0;
                        // A qualified 0 is farther than any real code, so it turns
                        if ((w_qual != 4'd0) && (w_qdist <= r_ref)) w_ref_nxt = w_qdist;
                        else                                        w_nxt     = ST_TURN;
                    end else if ((r_state == ST_TURN) && (w_leg_inc == LEG_W'(TURN_TICKS))) begin
                        w_nxt     = ST_APPROACH;
                        w_leg_nxt = '0;
                        if (w_qual != 4'd0) w_ref_nxt = w_qdist;
                    end
                end
                ST_ARRIVED: begin
                    w_lost_nxt = w_lost_cond ? w_lost_inc : '0;
                    if (w_lost_cond && (w_lost_inc == LOST_W'(LOST_TICKS))) begin
                        w_nxt      = ST_SEARCH;
                        w_lost_nxt = '0;
                    end
                end
                default: begin
                    w_nxt      = ST_IDLE;
                    w_leg_nxt  = '0;
                    w_lost_nxt = '0;
                end
            endcase
        end
    end

    // Motor/lock decode from the next state so they track nav_state exactly
    always_comb begin
        w_ml   = STOP;
        w_mr   = STOP;
        w_lock = 1'b0;
        case (w_nxt)
            ST_SEARCH:   begin w_ml = FWD; w_mr = REV; end
            ST_APPROACH: begin w_ml = FWD; w_mr = FWD; end
            ST_TURN:     begin w_ml = REV; w_mr = FWD; end
            ST_ARRIVED:  w_lock = 1'b1;
            default:     ;
        endcase
    end

endmodule

// File: tb/tb_freq_nav_controller.sv
// Directed table-driven bench for freq_nav_controller (one row per sample tick).
module tb_freq_nav_controller;

    localparam int SDIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] freq_state = 4'd0;
    logic [1:0] motor_left, motor_right;
    logic [3:0] qual_code;
    logic       locked;
    logic [2:0] nav_state;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] fs;
        logic       en;
        logic [2:0] st;
        logic [3:0] q;
    } vec_t;

    vec_t vt[$];

    always #5 clk = ~clk;

    freq_nav_controller #(
        .SAMPLE_DIV    (SDIV),
        .STABLE_SAMPLES(3),
        .TARGET_CODE   (14),
        .FWD_TICKS     (5),
        .TURN_TICKS    (3),
        .LOST_TICKS    (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .freq_state (freq_state),
        .enable     (enable),
        .motor_left (motor_left),
        .motor_right(motor_right),
        .qual_code  (qual_code),
        .locked     (locked),
        .nav_state  (nav_state)
    );

    task automatic add(input logic [3:0] fs, input logic en, input logic [2:0] st, input logic [3:0] q, input int n);
        vec_t v;
        v.fs = fs; v.en = en; v.st = st; v.q = q;
        for (int k = 0; k < n; k++) vt.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Expected motors/lock derived from the expected state encoding
    task automatic check_all(input string tag, input logic [2:0] st, input logic [3:0] q);
        logic [1:0] ml, mr;
        case (st)
            3'd1:    begin ml = 2'b01; mr = 2'b10; end
            3'd2:    begin ml = 2'b01; mr = 2'b01; end
            3'd3:    begin ml = 2'b10; mr = 2'b01; end
            default: begin ml = 2'b00; mr = 2'b00; end
        endcase
        chk({tag, ".state"}, 8'(nav_state), 8'(st));
        chk({tag, ".qual"},  8'(qual_code), 8'(q));
        chk({tag, ".ml"},    8'(motor_left), 8'(ml));
        chk({tag, ".mr"},    8'(motor_right), 8'(mr));
        chk({tag, ".lock"},  8'(locked), 8'(st == 3'd4));
    endtask

    // Drive one row, advance to just after the next tick edge
    task automatic step(input vec_t v);
        freq_state = v.fs;
        enable     = v.en;
        repeat (SDIV) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // st: 0 IDLE, 1 SEARCH, 2 APPROACH, 3 TURN, 4 ARRIVED
        add(0, 1, 1, 0, 1);   // t1  IDLE->SEARCH
        add(9, 1, 1, 0, 2);   // t2-3 partial run of 9
        add(0, 1, 1, 0, 1);   // t4  break
        add(9, 1, 1, 0, 2);   // t5-6
        add(9, 1, 1, 9, 1);   // t7  9 qualifies
        add(9, 1, 2, 9, 1);   // t8  APPROACH, ref=5
        add(10, 1, 2, 9, 2);  // t9-10
        add(10, 1, 2, 10, 3); // t11-13, leg end at t13: stay, ref=4
        add(9, 1, 2, 10, 2);  // t14-15
        add(9, 1, 2, 9, 2);   // t16-17
        add(9, 1, 3, 9, 3);   // t18 leg end: dist 5 > 4 -> TURN for 3 ticks
        add(9, 1, 2, 9, 1);   // t21 back to APPROACH
        add(14, 1, 2, 9, 2);  // t22-23
        add(14, 1, 2, 14, 1); // t24 target qualifies
        add(14, 1, 4, 14, 1); // t25 ARRIVED
        add(0, 1, 4, 14, 2);  // t26-27
        add(0, 1, 4, 0, 6);   // t28-33 lost count 1..5
        add(0, 1, 1, 0, 2);   // t34 back to SEARCH, t35 stays
        add(15, 1, 1, 0, 4);  // t36-39 out-of-band high
        add(3, 1, 1, 0, 4);   // t40-43 out-of-band low
        add(11, 1, 1, 0, 2);  // t44-45
        add(11, 1, 1, 11, 1); // t46
        add(11, 1, 2, 11, 2); // t47-48 APPROACH, ref=3
        // enable-drop sequence is hand-written between rows 48 and 49
        add(11, 1, 1, 11, 1); // t50 re-enable -> SEARCH
        add(11, 1, 2, 11, 1); // t51 APPROACH
        add(0, 1, 2, 11, 2);  // t52-53
        add(0, 1, 2, 0, 2);   // t54-55
        add(0, 1, 3, 0, 3);   // t56 leg end with code 0 -> TURN
        add(0, 1, 2, 0, 1);   // t59 turn done, lost=5
        add(0, 1, 1, 0, 1);   // t60 lost reaches 6 -> SEARCH

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset", 3'd0, 4'd0);
        reset = 1'b0;

        for (int i = 0; i < 48; i++) begin
            step(vt[i]);
            check_all($sformatf("row%0d", i + 1), vt[i].st, vt[i].q);
        end

        // enable low mid-APPROACH acts on the next clock, not the next tick
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all("en_drop", 3'd0, 4'd11);
        repeat (SDIV - 1) @(posedge clk);
        @(negedge clk);
        check_all("en_low_tick", 3'd0, 4'd11);

        for (int i = 48; i < vt.size(); i++) begin
            step(vt[i]);
            check_all($sformatf("row%0d", i + 2), vt[i].st, vt[i].q);
        end

        // reset mid-operation, then the first tick returns to SEARCH
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all("reset_mid", 3'd0, 4'd0);
        reset = 1'b0;
        begin
            vec_t v;
            v.fs = 4'd0; v.en = 1'b1; v.st = 3'd1; v.q = 4'd0;
            step(v);
            check_all("post_reset", v.st, v.q);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/freq_nav_controller.md
# freq_nav_controller

Downstream consumer of the frequency detector's 4-bit band code: it qualifies the code against chatter and then drives the rover's two motors. The drive pattern is search-spin, approach, and corrective turn, continuing until the target band is reached. It sits between the frequency detector and the motor driver H-bridge logic.

## Interface
- `SAMPLE_DIV`, 100000: clocks per sample tick; range ≥2.
- `STABLE_SAMPLES`, 8: consecutive identical ticks required to qualify a code; range ≥1.
- `TARGET_CODE`, 14: band code meaning "arrived"; range 7..14.
- `FWD_TICKS`, 500: ticks per forward approach leg.
- `TURN_TICKS`, 200: ticks per corrective turn.
- `LOST_TICKS`, 1000: consecutive ticks with qualified code 0 before falling back to search.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `freq_state` in 4: band code from the detector; 7..14 valid, anything else means "no tone".
- `enable` in 1: run request; low forces IDLE.
- `motor_left` out 2: 00 stop, 01 forward, 10 reverse, 11 never driven.
- `motor_right` out 2: same encoding as `motor_left`.
- `qual_code` out 4: current qualified code, 0 = none.
- `locked` out 1: high in ARRIVED.
- `nav_state` out 3: FSM state, for debug.

## Operation
- Tick generator:
  - Counter runs 0..SAMPLE_DIV-1 and wraps.
  - `tick` is asserted during the cycle the counter equals SAMPLE_DIV-1.
- Qualifier:
  - Runs on ticks only.
  - Input outside 7..14 is mapped to 0.
  - If the mapped input equals `cand`, `run` increments and saturates at STABLE_SAMPLES. Otherwise `cand` takes the mapped input and `run` resets to 1.
  - `qual_code` takes `cand` on the tick where `run` reaches STABLE_SAMPLES.
  - A qualified 0 is a legal qualified value.
- Distance: `dist(c) = |TARGET_CODE - c|`, a 4-bit unsigned value. It is only meaningful for c ≠ 0.
- FSM states and encodings:
  - IDLE=0: both motors stop.
  - SEARCH=1: spin; left forward, right reverse.
  - APPROACH=2: both forward.
  - TURN=3: spin; left reverse, right forward.
  - ARRIVED=4: stop; `locked` high.
- Transitions, evaluated on tick cycles except `enable` handling:
  - `enable` low, in any state: IDLE on the next clock, regardless of tick.
  - IDLE → SEARCH: on the first tick with `enable` high.
  - SEARCH → APPROACH: `qual_code` ≠ 0. At entry, latch `ref_dist = dist(qual_code)` and clear the leg counter.
  - APPROACH, leg counter reaches FWD_TICKS:
    - If `qual_code` ≠ 0 and `dist(qual_code)` ≤ `ref_dist`: stay in APPROACH, re-latch `ref_dist`, clear the leg counter.
    - If `dist(qual_code)` > `ref_dist`: go to TURN and clear the leg counter.
  - TURN → APPROACH: after TURN_TICKS ticks. Re-latch `ref_dist` if `qual_code` ≠ 0; otherwise keep the old value.
  - APPROACH/TURN → SEARCH: lost counter reaches LOST_TICKS. The lost counter increments on ticks with `qual_code` = 0 and clears otherwise.
  - SEARCH/APPROACH/TURN → ARRIVED: `qual_code` == TARGET_CODE.
  - ARRIVED → SEARCH: `qual_code` ≠ TARGET_CODE for LOST_TICKS ticks.
- Priority when events coincide on one tick: `enable` low, then ARRIVED, then lost→SEARCH, then leg-end decisions.

## Timing
- All outputs are registered.
- Reset values: `motor_left` = `motor_right` = 00, `qual_code` = 0, `locked` = 0, `nav_state` = IDLE. Reset also clears the tick counter, `cand`, `run`, and the leg/lost counters.
- Latencies:
  - `qual_code` updates 1 clock after the qualifying tick cycle.
  - The FSM reacts on the next tick after `qual_code` changes.
  - Motor outputs follow `nav_state` in the same cycle, since both are decoded into registers together.
- Fastest qualification: a new code appears on `qual_code` STABLE_SAMPLES ticks after its first sampled tick.
- Reset mid-leg discards all counters. `enable` low mid-leg also clears the leg and lost counters but preserves the qualifier state.

## Structure
- Package `freq_nav_pkg` holds:
  - Motor encodings: STOP, FWD, REV.
  - The FSM state enum.
  - Code bounds CODE_MIN=7 and CODE_MAX=14.
- One sub-module, `freq_code_qualifier`, contains the tick generator and the qualifier. It outputs `tick` and `qual_code`.
- The top level holds the FSM, the distance compare, and the leg/lost counters.

## Test plan
Parameters for all scenarios: SAMPLE_DIV=4, STABLE_SAMPLES=3, FWD_TICKS=5, TURN_TICKS=3, LOST_TICKS=6, TARGET_CODE=14.
- Reset with `enable`=1 and `freq_state`=0: IDLE, then SEARCH after the first tick. Motors 01/10, `qual_code`=0.
- Input 9 for 2 ticks, 0 for 1 tick, 9 for 3 ticks: `qual_code` becomes 9 only after the last 3-tick run. The FSM enters APPROACH with motors 01/01.
- Input 10 during APPROACH (from `ref_dist`=5) until the leg ends: stays in APPROACH with `ref_dist`=4. Switching input to 8 before the next leg end → TURN (10/01) for 3 ticks, then APPROACH.
- Input 14 held 3 ticks: ARRIVED, motors 00/00, `locked`=1. Dropping to 0 for 6 qualified ticks → SEARCH, `locked`=0.
- `enable` dropped mid-APPROACH: IDLE and 00/00 on the next clock. Re-asserting `enable` with code 11 still qualified → SEARCH, then APPROACH on the following tick.
- Input 15 or 3 held: treated as 0; `qual_code` stays 0 and the FSM stays in SEARCH.
